// File: rtl/uart_tx_if.sv
// CPU-side write port of the UART transmitter: write strobe and byte in, busy/done status out.
// No latency of its own; a bundle of wires.
// The master must respect busy. A write presented while busy is high is silently dropped.
`timescale 1ns/1ps
interface uart_tx_if;
    logic       wr;
    logic [7:0] tx_data;
    logic       busy;
    logic       done;

    modport master (output wr, output tx_data, input busy, input done);
    modport slave  (input wr, input tx_data, output busy, output done);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; optional TX FIFO when UART_TX_FIFO_EN is defined.
// Start bit begins at the accept (or pop) edge; frame is 10*DIV cycles, and done pulses at the final stop edge.
// Without the FIFO, busy is high for the whole frame. With the FIFO, busy means the FIFO is full. Writes made while busy are dropped.
`timescale 1ns/1ps
module uart_tx #(
    parameter int FREQ_MHZ   = 12,
    parameter int BAUDS      = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     resetq,
    uart_tx_if.slave bus,
    output logic     tx
);
    localparam int DIV = (FREQ_MHZ * 1000000) / BAUDS;
    localparam int BW  = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

    if (DIV < 2) begin : g_div_chk
        $error("uart_tx: clock divisor FREQ_MHZ*1e6/BAUDS must be at least 2");
    end
    if (FIFO_DEPTH < 2) begin : g_depth_chk
        $error("uart_tx: FIFO_DEPTH must be at least 2");
    end

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          ser_busy;
    logic          done_r;

    logic          baud_last;
    logic          start;
    logic [7:0]    start_dat;

    assign baud_last = (baud == BAUD_LAST);
    assign bus.done  = done_r;

`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;
    logic          full;
    logic          push;

    assign full      = (cnt == (AW+1)'(FIFO_DEPTH));
    // The serializer takes the next byte from idle or on the last stop-bit edge, so queued frames run gap-free.
    assign start     = (cnt != '0) && (!ser_busy || (state == STOP && baud_last));
    // A pop frees a slot in the same edge, so a write landing on it is still taken.
    assign push      = bus.wr && (!full || start);
    assign start_dat = mem[rp];
    assign bus.busy  = full;

    // FIFO storage: written on push only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) mem[wp] <= bus.tx_data;
    end

    // FIFO pointers and occupancy; reset flushes the queue.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (push)  wp <= wp + 1'b1;
            if (start) rp <= rp + 1'b1;
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(start);
        end
    end
`else
    assign start     = bus.wr && !ser_busy;
    assign start_dat = bus.tx_data;
    assign bus.busy  = ser_busy;
`endif

    // Frame sequencer: tx, busy and done all come straight from flops.
    always_ff @(posedge clk) begin
        if (!resetq) begin
            state    <= IDLE;
            tx       <= 1'b1;
            ser_busy <= 1'b0;
            done_r   <= 1'b0;
            baud     <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (start) begin
                        shreg    <= start_dat;
                        tx       <= 1'b0;
                        ser_busy <= 1'b1;
                        baud     <= '0;
                        bitcnt   <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_last) begin
                        baud   <= '0;
                        bitcnt <= '0;
                        tx     <= shreg[0];
                        state  <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_last) begin
                        baud <= '0;
                        if (bitcnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                            tx     <= shreg[1];
                            shreg  <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_last) begin
                        baud   <= '0;
                        done_r <= 1'b1;
                        // Only the FIFO build can chain a new frame here; otherwise start is low outside IDLE.
                        if (start) begin
                            shreg  <= start_dat;
                            tx     <= 1'b0;
                            bitcnt <= '0;
                            state  <= START;
                        end else begin
                            ser_busy <= 1'b0;
                            state    <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at DIV=8 (1 MHz, 125 kbaud): 80-cycle frames.
// Inputs change 1ns after the rising edge, and outputs are sampled at the same point.
// Expected bit streams are written out by hand, LSB first.
`timescale 1ns/1ps
module tb_uart_tx;
    logic clk = 1'b0;
    logic resetq;
    logic tx;
    int   total = 0;
    int   bad   = 0;

    uart_tx_if bus ();

    uart_tx #(.FREQ_MHZ(1), .BAUDS(125000), .FIFO_DEPTH(4)) dut (
        .clk    (clk),
        .resetq (resetq),
        .bus    (bus),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Caller is positioned just after the accept edge. bits[i] is the i-th data bit on the line.
    // Optionally injects a write at cycle inj_c of the frame.
    task automatic check_frame(input string tag, input logic [0:7] bits,
                               input int inj_c, input logic [7:0] inj_d);
        logic exp_tx;
        for (int c = 0; c < 80; c++) begin
            if (c < 8)       exp_tx = 1'b0;
            else if (c < 72) exp_tx = bits[c/8 - 1];
            else             exp_tx = 1'b1;
            chk({tag, "_tx"},   32'(tx),       32'(exp_tx));
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_done"}, 32'(bus.done), 32'd0);
            if (inj_c >= 0 && c == inj_c) begin
                bus.tx_data = inj_d;
                bus.wr      = 1'b1;
            end else if (inj_c >= 0 && c == inj_c + 1) begin
                bus.wr = 1'b0;
            end
            tick();
        end
        chk({tag, "_end_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_end_tx"},   32'(tx),       32'd1);
    endtask

    task automatic start_wr(input logic [7:0] d);
        bus.tx_data = d;
        bus.wr      = 1'b1;
        tick();
        bus.wr = 1'b0;
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_tx"},   32'(tx),       32'd1);
            chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
            chk({tag, "_done"}, 32'(bus.done), 32'd0);
            tick();
        end
    endtask

    initial begin
        resetq      = 1'b0;
        bus.wr      = 1'b0;
        bus.tx_data = 8'h00;
        tick();
        tick();
        chk("rst_tx",   32'(tx),       32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        resetq = 1'b1;
        idle_check("idle", 50);

`ifdef UART_TX_FIFO_EN
        begin
            logic [0:7] exp_bits [5];
            logic       exp_tx;
            int         n;
            int         c;
            exp_bits[0] = 8'b00001000;  // 8'h10
            exp_bits[1] = 8'b10001000;  // 8'h11
            exp_bits[2] = 8'b01001000;  // 8'h12
            exp_bits[3] = 8'b11001000;  // 8'h13
            exp_bits[4] = 8'b00101000;  // 8'h14
            bus.wr = 1'b1;
            for (int i = 0; i < 5; i++) begin
                bus.tx_data = 8'(8'h10 + i);
                tick();
            end
            chk("fifo_full_busy", 32'(bus.busy), 32'd1);
            bus.tx_data = 8'h15;
            tick();
            bus.wr = 1'b0;
            // First pop happened at the second write edge (t=0); we are now at t=4.
            for (int t = 4; t < 402; t++) begin
                n = t / 80;
                c = t % 80;
                if (n >= 5)      exp_tx = 1'b1;
                else if (c < 8)  exp_tx = 1'b0;
                else if (c < 72) exp_tx = exp_bits[n][c/8 - 1];
                else             exp_tx = 1'b1;
                chk("fifo_tx",   32'(tx),       32'(exp_tx));
                chk("fifo_done", 32'(bus.done), (n >= 1 && c == 0) ? 32'd1 : 32'd0);
                if (t == 80) chk("fifo_busy_drop", 32'(bus.busy), 32'd0);
                tick();
            end
            idle_check("fifo_idle", 20);
        end
`else
        start_wr(8'h55);
        check_frame("f55", 8'b10101010, -1, 8'h00);
        tick();
        idle_check("after55", 5);

        start_wr(8'hA3);
        check_frame("fA3", 8'b11000101, 20, 8'hFF);
        tick();
        idle_check("afterA3", 90);

        start_wr(8'h00);
        repeat (35) tick();
        chk("mid_tx", 32'(tx), 32'd0);
        resetq = 1'b0;
        tick();
        resetq = 1'b1;
        chk("midrst_tx",   32'(tx),       32'd1);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        idle_check("midrst_idle", 10);
        start_wr(8'h0F);
        check_frame("f0F", 8'b11110000, -1, 8'h00);
        tick();
        idle_check("after0F", 5);

        bus.tx_data = 8'h01;
        bus.wr      = 1'b1;
        tick();
        check_frame("c01a", 8'b10000000, -1, 8'h00);
        // wr still high: the next accept is the edge after done, giving a 9-cycle stop bit.
        tick();
        bus.wr = 1'b0;
        check_frame("c01b", 8'b10000000, -1, 8'h00);
        tick();
        idle_check("afterc01", 10);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Standalone UART transmitter (8N1): serializes bytes written by the CPU-side UART peripheral onto the TXD pin.
- Transmit-direction counterpart of the receive path. Shares the same FREQ_MHZ/BAUDS timing convention, so the same divisor applies on both ends of the link.
- Exposes a write strobe plus a busy flag, suitable for direct mapping onto the UART data register.

Parameters:
- FREQ_MHZ, 12, system clock frequency in MHz (integer).
- BAUDS, 115200, line rate in bit/s.
- FIFO_DEPTH, 4, TX buffer entries (power of 2, >=2). Used only when UART_TX_FIFO_EN is defined.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- resetq  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- wr  in  1  write strobe; high for one or more cycles, each sampled cycle is a write request.
- tx_data  in  8  byte to send, sampled on the cycle wr is accepted.
- tx  out  1  serial output (idle high).
- busy  out  1  1 = write would be dropped (serializer active, or FIFO full when FIFO compiled in).
- done  out  1  one-cycle pulse when a frame's stop bit completes.

Behaviour:
- Divisor DIV = (FREQ_MHZ*1000000)/BAUDS, integer truncation. Elaboration error if DIV < 2. Defaults give DIV = 104.
- Reset (resetq=0 at an edge): tx=1, busy=0, done=0, state=IDLE, bit counter=0, baud counter=0, FIFO empty.
- Reset mid-frame: the frame is abandoned and tx returns to 1 on that edge. No partial stop bit is emitted.
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1. At an edge with wr=1 and busy=0:
  - latch tx_data into the shift register;
  - tx<=0, busy<=1, baud counter<=0;
  - go to START.
- wr while busy=1 is ignored; the data is lost and there is no error flag.
- START: hold tx=0 for DIV cycles, then go to DATA, drive bit0 and set the bit counter to 0.
- DATA: each bit is held DIV cycles, LSB first. After bit7's DIV cycles, tx<=1 and go to STOP.
- STOP: hold tx=1 for DIV cycles. On the final edge: state<=IDLE, busy<=0, done<=1 for exactly one cycle.
- Timing: if wr is accepted at edge k, the start bit occupies cycles k..k+DIV-1 (tx low after edge k). Data bit i begins at edge k+DIV*(i+1). The stop bit begins at edge k+9*DIV. busy falls and done pulses at edge k+10*DIV.
- The earliest next accept without FIFO is edge k+10*DIV+1. The stop bit is therefore DIV+1 cycles when writes are back-to-back, which is legal.
- Baud counter width: clog2(DIV). It counts 0..DIV-1 and wraps.
- tx is driven directly from a flop (glitch-free). No combinational path from wr to tx.
- tx_data changes while busy have no effect on the frame in flight.

Optional Feature:
- UART_TX_FIFO_EN defined:
  - A FIFO_DEPTH-entry FIFO sits in front of the serializer.
  - wr pushes when the FIFO is not full. busy = FIFO full.
  - The serializer pops when in IDLE with the FIFO non-empty. On a pop it starts the frame at the same edge timing as a direct accept.
  - Back-to-back frames: pop occurs at the STOP-final edge. The next start bit begins at k+10*DIV with no extra idle cycle.
  - done still pulses once per frame.
  - Simultaneous push and pop when full is allowed, FIFO stays full. Occupancy counter width is clog2(FIFO_DEPTH)+1.
  - Reset flushes the FIFO.
- UART_TX_FIFO_EN undefined: no FIFO logic is synthesized; behaviour is exactly as in the Behaviour section.

Test Plan (FREQ_MHZ=1, BAUDS=125000 -> DIV=8, frame = 80 cycles):
- Reset then idle 50 cycles -> tx=1, busy=0, done=0 throughout.
- Single wr with tx_data=8'h55 -> tx: 8 cycles 0, then bits 1,0,1,0,1,0,1,0 at 8 cycles each, then 8 cycles 1. busy high for exactly 80 cycles; done pulses 1 cycle at edge 80.
- wr with 8'hA3, then wr with 8'hFF at cycle 20 (busy=1) -> only A3 is transmitted (bits 1,1,0,0,0,1,0,1). 8'hFF is never seen on tx.
- resetq=0 for one edge at cycle 35 of an 8'h00 frame -> tx=1 on the next cycle, busy=0. A following wr of 8'h0F produces a clean full frame.
- Continuous wr of 8'h01 with wr held high (no FIFO) -> consecutive frames separated by a 9-cycle stop bit. Each frame is correct.
- (UART_TX_FIFO_EN, FIFO_DEPTH=4) 6 wr in consecutive cycles of 8'h10..8'h15 -> 8'h10..8'h14 accepted; 8'h15 dropped with busy=1 at that cycle. Five frames sent gap-free in order (400 cycles), with 5 done pulses.
